rps_round_ctrl: RTL and testbench
=================================

// Module: rps_round_ctrl
// PURPOSE
//   Game sequencer for the Markov rock-paper-scissors predictor. Owns a 27-entry transition-count RAM (9 prev-round states x 3 user moves).
//   Clears the RAM, presents an AI choice, accepts the user move, updates the counts and scores the round.
//   Sits between the switch/key front end and the count RAM; it is the only RAM master.
//   Move encoding: 2'b00 rock, 2'b01 scissor, 2'b10 paper; 2'b11 is illegal.
// PARAMETERS
//   CNT_W       8    width of each transition counter / RAM word
//   MAX_ROUNDS  60   rounds per game; game_over asserts after this many scored rounds
// PORTS
//   clock        in   1      system clock; all state on posedge
//   reset        in   1      asynchronous, active-high; clears all state
//   start        in   1      1-cycle pulse: begin a new game (clear RAM, zero scores)
//   move_valid   in   1      user move offered
//   move_ready   out  1      high only in WAIT; transfer when move_valid & move_ready
//   move         in   2      user move, sampled on transfer
//   rand_in      in   2      free-running random source (value 3 is treated as 0)
//   ai_choice    out  2      AI move for the current round; stable while ai_valid
//   ai_valid     out  1      ai_choice committed; high throughout WAIT
//   mat_addr     out  5      RAM address = row*3 + col, row = prev state 0..8, col = user move 0..2
//   mat_we       out  1      RAM write strobe
//   mat_wdata    out  CNT_W  RAM write data
//   mat_rdata    in   CNT_W  RAM read data; synchronous, valid the cycle after mat_addr
//   result_valid out  1      1-cycle pulse per scored round
//   result       out  2      2'b00 tie, 2'b01 AI win, 2'b10 user win; held until the next pulse
//   wins/losses/ties out 8   AI-perspective score counters, saturating at 255
//   round_cnt    out  6      scored rounds this game
//   game_over    out  1      high from round MAX_ROUNDS until the next start
//   move_err     out  1      1-cycle pulse when an illegal move (2'b11) is transferred
// BEHAVIOUR
//   - Reset: state IDLE; all outputs 0; hist_valid=0; prev=0.
//   - States: IDLE -> CLEAR -> PRED_RD0 -> PRED_RD1 -> PRED_RD2 -> PRED_EV -> WAIT -> UPD_RD -> UPD_WR -> SCORE -> PRED_RD0 (or DONE).
//   - IDLE: waits for start.
//   - CLEAR: 27 cycles, mat_we=1, mat_wdata=0, mat_addr 0..26. Zeroes the scores, round_cnt and hist_valid.
//   - PRED_RD0..2: mat_addr = prev*3+0,1,2. Data is captured one cycle later, so the third word is captured in PRED_EV.
//   - PRED_EV: predicted user move u = argmax of the 3 counts. ai_choice = beat(u), where beat(rock)=paper, beat(scissor)=rock, beat(paper)=scissor.
//     If hist_valid=0, ai_choice = rand_in (3 maps to 0). ai_valid rises on entry to WAIT.
//   - WAIT: move_ready=1.
//     On transfer of an illegal move: pulse move_err, stay in WAIT, leave ai_choice unchanged.
//     On transfer of a legal move: latch it, drop ai_valid and move_ready, go to UPD_RD.
//   - UPD_RD: if hist_valid, mat_addr = prev*3+move.
//   - UPD_WR: if hist_valid, mat_we=1, mat_wdata = rdata+1, saturating at 2^CNT_W-1 (a saturated word rewrites the same value).
//     If hist_valid=0, no write in either state.
//   - SCORE: result per the rules above, result_valid=1, bump the matching counter and round_cnt.
//     Set prev = move*3 + ai_choice and hist_valid=1.
//     If round_cnt reaches MAX_ROUNDS, go to DONE with game_over=1; otherwise go to PRED_RD0.
//   - Latency: start -> first ai_valid = 32 cycles. Move transfer -> result_valid = 3 cycles. result_valid -> next ai_valid = 5 cycles.
//   - start in any non-IDLE state (including DONE and mid-CLEAR) aborts the current game and re-enters CLEAR at address 0 the next cycle.
//   - reset mid-operation returns to IDLE immediately. RAM contents are undefined until the next CLEAR completes.
//   - mat_we is never asserted outside CLEAR and UPD_WR.
// CONFIGURATION
//   RPS_TIE_RANDOM_EN defined:
//     - PRED_EV ties are broken by rand_in among the tied moves. rand_in mod the tie count indexes the tied moves in ascending encoding.
//     - A 3-way tie with rand_in=3 selects index 0.
//   RPS_TIE_RANDOM_EN undefined:
//     - Ties go to the lowest-encoded move (rock before scissor before paper).
//     - rand_in is used only when hist_valid=0.
// TESTING
//   (Build without RPS_TIE_RANDOM_EN unless noted.)
//   1. reset, start: 27 writes of 0 to addrs 0..26. With rand_in=2, ai_valid=1 and ai_choice=2'b10 at cycle 32.
//   2. First round, ai=paper, user rock: no RAM write; result=01; wins=1; prev=2.
//   3. Preload row 2 with counts {5,1,1}: ai_choice=paper.
//      Then user scissor against AI paper: addr 7 is written with 2 (RAM pre-count 1), result=10, losses=1.
//   4. Row all-equal {3,3,3}: ai=paper.
//      With RPS_TIE_RANDOM_EN and rand_in=1: predicted move is scissor, so ai=rock.
//   5. Move 2'b11 in WAIT: one move_err pulse, no RAM activity, ai_choice unchanged.
//      RAM word at 255 updated: it stays 255.
//   6. 60 legal rounds -> game_over=1, round_cnt=60, move_ready=0.
//      start pulse mid-UPD_WR or reset mid-CLEAR: the bench checks the abort/IDLE timing defined under BEHAVIOUR.

Source files
------------

// File: rtl/rps_round_ctrl_if.sv
// Bus bundle between the RPS round sequencer (master) and its front end / count RAM (slave).
interface rps_round_ctrl_if #(
  parameter int CNT_W = 8
);
  logic             start;
  logic [1:0]       rand_in;
  logic             move_valid;
  logic             move_ready;
  logic [1:0]       move;
  logic [1:0]       ai_choice;
  logic             ai_valid;
  logic [4:0]       mat_addr;
  logic             mat_we;
  logic [CNT_W-1:0] mat_wdata;
  logic [CNT_W-1:0] mat_rdata;
  logic             result_valid;
  logic [1:0]       result;
  logic [7:0]       wins;
  logic [7:0]       losses;
  logic [7:0]       ties;
  logic [5:0]       round_cnt;
  logic             game_over;
  logic             move_err;

  modport master (
    input  start, rand_in, move_valid, move, mat_rdata,
    output move_ready, ai_choice, ai_valid, mat_addr, mat_we, mat_wdata,
           result_valid, result, wins, losses, ties, round_cnt, game_over, move_err
  );

  modport slave (
    output start, rand_in, move_valid, move, mat_rdata,
    input  move_ready, ai_choice, ai_valid, mat_addr, mat_we, mat_wdata,
           result_valid, result, wins, losses, ties, round_cnt, game_over, move_err
  );
endinterface

// File: rtl/rps_round_ctrl.sv
// Markov rock-paper-scissors round sequencer: clears the count RAM, predicts, takes moves, scores.
// Optional macro RPS_TIE_RANDOM_EN: prediction ties are broken by rand_in instead of lowest encoding.
module rps_round_ctrl #(
  parameter int CNT_W      = 8,
  parameter int MAX_ROUNDS = 60
) (
  input logic              clock,
  input logic              reset,
  rps_round_ctrl_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_CLEAR, S_PRED_RD0, S_PRED_RD1, S_PRED_RD2, S_PRED_EV,
    S_WAIT, S_UPD_RD, S_UPD_WR, S_SCORE, S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [4:0]       clr_addr_q;
  logic [3:0]       prev_q;
  logic             hist_q;
  logic [1:0]       move_q;
  logic [1:0]       ai_q;
  logic [1:0]       result_q;
  logic [CNT_W-1:0] cnt0_q, cnt1_q;
  logic [7:0]       wins_q, losses_q, ties_q;
  logic [5:0]       round_q;

  logic [4:0]       row_base;
  logic [1:0]       pred_u;
  logic [1:0]       rnd_map;
  logic [1:0]       judge_w;
  logic             xfer_ok;

  function automatic logic [1:0] beat(input logic [1:0] u);
    case (u)
      2'd0:    beat = 2'd2;
      2'd1:    beat = 2'd0;
      default: beat = 2'd1;
    endcase
  endfunction

  function automatic logic [1:0] judge(input logic [1:0] ai, input logic [1:0] usr);
    if (ai == usr)            judge = 2'b00;
    else if (beat(usr) == ai) judge = 2'b01;
    else                      judge = 2'b10;
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    sat_inc = (&v) ? v : v + 1'b1;
  endfunction

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    sat_inc8 = (&v) ? v : v + 8'd1;
  endfunction

`ifdef RPS_TIE_RANDOM_EN
  function automatic logic [1:0] predict(input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1,
                                         input logic [CNT_W-1:0] c2, input logic [1:0] rnd);
    logic [CNT_W-1:0] mx;
    logic [2:0]       t;
    logic [1:0]       n, idx, seen;
    mx = (c0 >= c1) ? c0 : c1;
    if (c2 > mx) mx = c2;
    t = {c2 == mx, c1 == mx, c0 == mx};
    n = 2'(t[0]) + 2'(t[1]) + 2'(t[2]);
    // idx = rnd mod n, taken over the tied moves in ascending encoding
    if (n == 2'd3)      idx = (rnd == 2'd3) ? 2'd0 : rnd;
    else if (n == 2'd2) idx = {1'b0, rnd[0]};
    else                idx = 2'd0;
    predict = 2'd0;
    seen    = 2'd0;
    for (int k = 0; k < 3; k++) begin
      if (t[k]) begin
        if (seen == idx) predict = 2'(k);
        seen = seen + 2'd1;
      end
    end
  endfunction

  assign pred_u = predict(cnt0_q, cnt1_q, bus.mat_rdata, bus.rand_in);
`else
  function automatic logic [1:0] predict(input logic [CNT_W-1:0] c0, input logic [CNT_W-1:0] c1,
                                         input logic [CNT_W-1:0] c2);
    if (c0 >= c1 && c0 >= c2) predict = 2'd0;
    else if (c1 >= c2)        predict = 2'd1;
    else                      predict = 2'd2;
  endfunction

  assign pred_u = predict(cnt0_q, cnt1_q, bus.mat_rdata);
`endif

  assign row_base = {1'b0, prev_q} * 5'd3;
  assign rnd_map  = (bus.rand_in == 2'd3) ? 2'd0 : bus.rand_in;
  assign judge_w  = judge(ai_q, move_q);
  assign xfer_ok  = bus.move_valid && (bus.move != 2'b11);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (bus.start) begin
      state_d = S_CLEAR;
    end else begin
      case (state_q)
        S_IDLE:     state_d = S_IDLE;
        S_CLEAR:    if (clr_addr_q == 5'd26) state_d = S_PRED_RD0;
        S_PRED_RD0: state_d = S_PRED_RD1;
        S_PRED_RD1: state_d = S_PRED_RD2;
        S_PRED_RD2: state_d = S_PRED_EV;
        S_PRED_EV:  state_d = S_WAIT;
        S_WAIT:     if (xfer_ok) state_d = S_UPD_RD;
        S_UPD_RD:   state_d = S_UPD_WR;
        S_UPD_WR:   state_d = S_SCORE;
        S_SCORE:    state_d = (round_q == 6'(MAX_ROUNDS)) ? S_DONE : S_PRED_RD0;
        S_DONE:     state_d = S_DONE;
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.move_ready   = 1'b0;
    bus.ai_valid     = 1'b0;
    bus.mat_addr     = 5'd0;
    bus.mat_we       = 1'b0;
    bus.mat_wdata    = '0;
    bus.result_valid = 1'b0;
    bus.game_over    = 1'b0;
    bus.move_err     = 1'b0;
    case (state_q)
      S_CLEAR: begin
        bus.mat_we   = 1'b1;
        bus.mat_addr = clr_addr_q;
      end
      S_PRED_RD0: bus.mat_addr = row_base;
      S_PRED_RD1: bus.mat_addr = row_base + 5'd1;
      S_PRED_RD2: bus.mat_addr = row_base + 5'd2;
      S_WAIT: begin
        bus.move_ready = 1'b1;
        bus.ai_valid   = 1'b1;
        bus.move_err   = bus.move_valid && (bus.move == 2'b11);
      end
      S_UPD_RD: if (hist_q) bus.mat_addr = row_base + {3'b000, move_q};
      S_UPD_WR: begin
        if (hist_q) begin
          bus.mat_addr  = row_base + {3'b000, move_q};
          bus.mat_we    = 1'b1;
          bus.mat_wdata = sat_inc(bus.mat_rdata);
        end
      end
      S_SCORE: bus.result_valid = 1'b1;
      S_DONE:  bus.game_over    = 1'b1;
      default: ;
    endcase
  end

  assign bus.ai_choice = ai_q;
  assign bus.result    = result_q;
  assign bus.wins      = wins_q;
  assign bus.losses    = losses_q;
  assign bus.ties      = ties_q;
  assign bus.round_cnt = round_q;

  // Round datapath: third prediction word is used straight off mat_rdata in PRED_EV.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clr_addr_q <= 5'd0;
      prev_q     <= 4'd0;
      hist_q     <= 1'b0;
      move_q     <= 2'd0;
      ai_q       <= 2'd0;
      result_q   <= 2'd0;
      cnt0_q     <= '0;
      cnt1_q     <= '0;
      wins_q     <= 8'd0;
      losses_q   <= 8'd0;
      ties_q     <= 8'd0;
      round_q    <= 6'd0;
    end else if (bus.start) begin
      clr_addr_q <= 5'd0;
      prev_q     <= 4'd0;
      hist_q     <= 1'b0;
      wins_q     <= 8'd0;
      losses_q   <= 8'd0;
      ties_q     <= 8'd0;
      round_q    <= 6'd0;
    end else begin
      case (state_q)
        S_CLEAR:    clr_addr_q <= clr_addr_q + 5'd1;
        S_PRED_RD1: cnt0_q <= bus.mat_rdata;
        S_PRED_RD2: cnt1_q <= bus.mat_rdata;
        S_PRED_EV:  ai_q   <= hist_q ? beat(pred_u) : rnd_map;
        S_WAIT:     if (xfer_ok) move_q <= bus.move;
        S_UPD_WR: begin
          result_q <= judge_w;
          round_q  <= round_q + 6'd1;
          case (judge_w)
            2'b00:   ties_q   <= sat_inc8(ties_q);
            2'b01:   wins_q   <= sat_inc8(wins_q);
            default: losses_q <= sat_inc8(losses_q);
          endcase
        end
        S_SCORE: begin
          prev_q <= {2'b00, move_q} * 4'd3 + {2'b00, ai_q};
          hist_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rps_round_ctrl.sv
// Self-checking bench for rps_round_ctrl: behavioural count RAM plus a game-level reference model.
`timescale 1ns/1ps
module tb_rps_round_ctrl;
  localparam int CNT_W      = 8;
  localparam int MAX_ROUNDS = 60;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  rps_round_ctrl_if #(.CNT_W(CNT_W)) bus();

  rps_round_ctrl #(.CNT_W(CNT_W), .MAX_ROUNDS(MAX_ROUNDS)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  // Count RAM with synchronous read, plus a side door for preloading rows
  logic [CNT_W-1:0] mem [32];
  logic [CNT_W-1:0] pk_val [3];
  int pk_base = 0;
  int pk_seq  = 0;
  int pk_done = 0;
  int wr_cnt  = 0;
  int err_cnt = 0;

  always @(posedge clock) begin
    if (pk_seq != pk_done) begin
      for (int k = 0; k < 3; k++) mem[pk_base + k] <= pk_val[k];
      pk_done <= pk_seq;
    end
    if (bus.mat_we) begin
      mem[bus.mat_addr] <= bus.mat_wdata;
      wr_cnt <= wr_cnt + 1;
    end
    bus.mat_rdata <= mem[bus.mat_addr];
    if (bus.move_err) err_cnt <= err_cnt + 1;
  end

  // Game-level reference model
  int m_cnt [27];
  bit m_hist;
  int m_prev, m_w, m_l, m_t, m_rounds;
  int g_rnd;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_chk++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  function automatic int beat_of(input int u);
    return (u == 0) ? 2 : (u == 1) ? 0 : 1;
  endfunction

  function automatic int exp_ai(input int rnd);
    int mx, best;
    int tied[$];
    if (!m_hist) return (rnd == 3) ? 0 : rnd;
    mx = 0;
    for (int k = 0; k < 3; k++) if (m_cnt[m_prev*3 + k] > mx) mx = m_cnt[m_prev*3 + k];
    for (int k = 0; k < 3; k++) if (m_cnt[m_prev*3 + k] == mx) tied.push_back(k);
`ifdef RPS_TIE_RANDOM_EN
    best = tied[rnd % tied.size()];
`else
    best = tied[0];
`endif
    return beat_of(best);
  endfunction

  task automatic poke_row(input int row, input int v0, input int v1, input int v2);
    pk_base   = row * 3;
    pk_val[0] = CNT_W'(v0);
    pk_val[1] = CNT_W'(v1);
    pk_val[2] = CNT_W'(v2);
    m_cnt[row*3]     = v0;
    m_cnt[row*3 + 1] = v1;
    m_cnt[row*3 + 2] = v2;
    pk_seq++;
  endtask

  // Called at a negedge; pulses start and follows the clear up to the first ai_valid.
  task automatic start_game(input int rnd);
    int lat, clr_good;
    lat = 0; clr_good = 0;
    g_rnd = rnd;
    bus.rand_in = 2'(rnd);
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clock);
      if (cyc == 1) begin
        bus.start = 1'b0;
        chk("clr_first_we", bus.mat_we, 1);
        chk("clr_first_addr", bus.mat_addr, 0);
        chk("clr_no_result", bus.result_valid, 0);
      end
      if (cyc <= 27 && bus.mat_we && bus.mat_addr == 5'(cyc - 1) && bus.mat_wdata == '0) clr_good++;
      if (bus.ai_valid) begin lat = cyc; break; end
    end
    chk("clr_writes", clr_good, 27);
    chk("start_lat", lat, 32);
    for (int k = 0; k < 27; k++) m_cnt[k] = 0;
    m_hist = 0; m_prev = 0; m_w = 0; m_l = 0; m_t = 0; m_rounds = 0;
    chk("start_wins", bus.wins, 0);
    chk("start_rounds", bus.round_cnt, 0);
    chk("start_over", bus.game_over, 0);
  endtask

  // Called at a negedge in WAIT; ends at the negedge of the SCORE cycle.
  task automatic play_round(input int u, input int idle, input int nxt_rnd);
    int a, lat, w0, addr, r;
    a = exp_ai(g_rnd);
    chk("ai_valid", bus.ai_valid, 1);
    chk("ai_choice", bus.ai_choice, a);
    chk("move_ready", bus.move_ready, 1);
    for (int i = 0; i < idle; i++) @(negedge clock);
    w0 = wr_cnt;
    bus.move_valid = 1'b1;
    bus.move = 2'(u);
    lat = 0;
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(negedge clock);
      if (cyc == 1) bus.move_valid = 1'b0;
      if (bus.result_valid) begin lat = cyc; break; end
    end
    chk("res_lat", lat, 3);
    addr = m_prev * 3 + u;
    if (m_hist && m_cnt[addr] < CMAX) m_cnt[addr]++;
    r = (a == u) ? 0 : (beat_of(u) == a) ? 1 : 2;
    if (r == 0) m_t++; else if (r == 1) m_w++; else m_l++;
    m_rounds++;
    chk("result", bus.result, r);
    chk("wins", bus.wins, m_w);
    chk("losses", bus.losses, m_l);
    chk("ties", bus.ties, m_t);
    chk("round_cnt", bus.round_cnt, m_rounds);
    chk("ram_writes", wr_cnt - w0, m_hist ? 1 : 0);
    if (m_hist) chk("ram_word", mem[addr], m_cnt[addr]);
    m_prev = u * 3 + a;
    m_hist = 1;
    g_rnd = nxt_rnd;
    bus.rand_in = 2'(nxt_rnd);
  endtask

  task automatic wait_ai();
    int lat;
    lat = 0;
    for (int cyc = 1; cyc <= 12; cyc++) begin
      @(negedge clock);
      if (bus.ai_valid) begin lat = cyc; break; end
    end
    chk("ai_lat", lat, 5);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int e0, w0, a0, row, u, viol;
    bus.start = 1'b0;
    bus.rand_in = 2'd0;
    bus.move_valid = 1'b0;
    bus.move = 2'd0;
    m_hist = 0; m_prev = 0; m_w = 0; m_l = 0; m_t = 0; m_rounds = 0; g_rnd = 0;

    repeat (3) @(negedge clock);
    chk("rst_ai_valid", bus.ai_valid, 0);
    chk("rst_move_ready", bus.move_ready, 0);
    chk("rst_we", bus.mat_we, 0);
    chk("rst_result_valid", bus.result_valid, 0);
    chk("rst_ai_choice", bus.ai_choice, 0);
    chk("rst_round_cnt", bus.round_cnt, 0);
    chk("rst_game_over", bus.game_over, 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);
    chk("idle_we", bus.mat_we, 0);

    // Game 1: directed openings, then random play to the round limit
    start_game(2);
    chk("first_ai_paper", bus.ai_choice, 2);
    play_round(0, 0, 1);
    chk("r1_result", bus.result, 1);
    chk("r1_wins", bus.wins, 1);
    poke_row(2, 5, 1, 1);
    wait_ai();
    chk("r2_ai", bus.ai_choice, 2);
    play_round(1, 0, 1);
    chk("r2_addr7", mem[7], 2);
    chk("r2_result", bus.result, 2);
    poke_row(5, 3, 3, 3);
    wait_ai();
`ifdef RPS_TIE_RANDOM_EN
    chk("tie_ai", bus.ai_choice, 0);
`else
    chk("tie_ai", bus.ai_choice, 2);
`endif
    e0 = err_cnt; w0 = wr_cnt; a0 = bus.ai_choice;
    bus.move_valid = 1'b1;
    bus.move = 2'b11;
    @(negedge clock);
    bus.move_valid = 1'b0;
    chk("err_pulse", err_cnt - e0, 1);
    chk("err_no_write", wr_cnt - w0, 0);
    chk("err_ai_held", bus.ai_choice, a0);
    chk("err_still_wait", bus.move_ready, 1);
    play_round($urandom_range(2, 0), 1, $urandom_range(3, 0));
    row = m_prev;
    poke_row(row, CMAX, CMAX, CMAX);
    wait_ai();
    u = $urandom_range(2, 0);
    play_round(u, 0, $urandom_range(3, 0));
    chk("sat_word", mem[row*3 + u], CMAX);
    while (m_rounds < MAX_ROUNDS) begin
      wait_ai();
      play_round($urandom_range(2, 0), $urandom_range(2, 0), $urandom_range(3, 0));
    end
    @(negedge clock);
    chk("done_over", bus.game_over, 1);
    chk("done_rounds", bus.round_cnt, MAX_ROUNDS);
    chk("done_ready", bus.move_ready, 0);
    chk("done_ai_valid", bus.ai_valid, 0);

    // Game 2: restart from DONE, then abort mid-update
    start_game($urandom_range(3, 0));
    play_round($urandom_range(2, 0), 0, $urandom_range(3, 0));
    wait_ai();
    play_round($urandom_range(2, 0), 0, $urandom_range(3, 0));
    wait_ai();
    bus.move_valid = 1'b1;
    bus.move = 2'($urandom_range(2, 0));
    @(negedge clock);
    bus.move_valid = 1'b0;
    @(negedge clock);
    chk("abort_upd_we", bus.mat_we, 1);
    start_game($urandom_range(3, 0));

    // Reset part-way through CLEAR
    bus.start = 1'b1;
    @(negedge clock);
    bus.start = 1'b0;
    repeat (9) @(negedge clock);
    chk("midclr_we", bus.mat_we, 1);
    reset = 1'b1;
    #1;
    chk("rst_midclr_we", bus.mat_we, 0);
    chk("rst_midclr_addr", bus.mat_addr, 0);
    chk("rst_midclr_ready", bus.move_ready, 0);
    @(negedge clock);
    reset = 1'b0;
    w0 = wr_cnt;
    viol = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (bus.ai_valid || bus.mat_we) viol++;
    end
    chk("idle_quiet", viol, 0);
    chk("idle_writes", wr_cnt - w0, 0);

    // Fresh game with rand_in=3 folds to rock
    start_game(3);
    chk("rand3_ai", bus.ai_choice, 0);
    play_round($urandom_range(2, 0), 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
